axi_lite_responder: RTL and testbench

AXI_LITE_RESPONDER -- requirements
Module: axi_lite_responder

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_bytewrite.sv | 17 +
 rtl/axi_lite_responder.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-lite register responder.
// Write/read FSM states, response codes and the RW register count.
package axi_lite_pkg;

  localparam int NUM_RW_REGS = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_lite_bytewrite.sv
// Strobe-masked merge of one 32-bit word.
// Ports: old_i (current word), new_i (write data), strb_i (byte enables), merged_o.
module axi_lite_bytewrite (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < 4; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_responder.sv
// AXI-lite slave with 8 RW control words and 8 RO status words.
// Ports: AXI AW/W/B/AR/R channels, ctrl_out, status_in, wr_pulse.
module axi_lite_responder
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int BASE_IDX_BITS = 4
) (
  input  logic                  AXI_CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] AXI_awaddr,
  input  logic                  AXI_awvalid,
  output logic                  AXI_awready,
  input  logic [31:0]           AXI_wdata,
  input  logic [3:0]            AXI_wstrb,
  input  logic                  AXI_wvalid,
  output logic                  AXI_wready,
  output logic [1:0]            AXI_bresp,
  output logic                  AXI_bvalid,
  input  logic                  AXI_bready,
  input  logic [ADDR_WIDTH-1:0] AXI_araddr,
  input  logic                  AXI_arvalid,
  output logic                  AXI_arready,
  output logic [31:0]           AXI_rdata,
  output logic [1:0]            AXI_rresp,
  output logic                  AXI_rvalid,
  input  logic                  AXI_rready,
  output logic [255:0]          ctrl_out,
  input  logic [255:0]          status_in,
  output logic [7:0]            wr_pulse
);

  localparam int IH = BASE_IDX_BITS + 1;
  localparam int CW = 32 * NUM_RW_REGS;

  wstate_e ws_q, ws_d;
  rstate_e rs_q, rs_d;

  logic [CW-1:0]          ctrl_q, ctrl_d;
  logic [NUM_RW_REGS-1:0] pulse_q, pulse_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  aw_idx_q;
  logic        aw_oor_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_done, wr_ok;
  logic [3:0]  aw_idx, ar_idx, wr_idx;
  logic        aw_oor, ar_oor, wr_oor;
  logic [31:0] wr_data, old_word, new_word;
  logic [3:0]  wr_strb;
  logic        unused_lsb;

  assign unused_lsb = ^{AXI_awaddr[1:0], AXI_araddr[1:0]};

  assign aw_idx = AXI_awaddr[IH:2];
  assign ar_idx = AXI_araddr[IH:2];
  assign aw_oor = |AXI_awaddr[ADDR_WIDTH-1:IH+1];
  assign ar_oor = |AXI_araddr[ADDR_WIDTH-1:IH+1];

  always_comb begin
    ws_d        = ws_q;
    AXI_awready = 1'b0;
    AXI_wready  = 1'b0;
    AXI_bvalid  = 1'b0;
    unique case (ws_q)
      W_IDLE: begin
        AXI_awready = ~RESET;
        AXI_wready  = ~RESET;
      end
      W_HAVE_A: AXI_wready  = ~RESET;
      W_HAVE_D: AXI_awready = ~RESET;
      W_RESP:   AXI_bvalid  = 1'b1;
    endcase
    aw_hs = AXI_awvalid & AXI_awready;
    w_hs  = AXI_wvalid & AXI_wready;
    unique case (ws_q)
      W_IDLE: begin
        if (aw_hs && w_hs) ws_d = W_RESP;
        else if (aw_hs)    ws_d = W_HAVE_A;
        else if (w_hs)     ws_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  ws_d = W_RESP;
      W_HAVE_D: if (aw_hs) ws_d = W_RESP;
      W_RESP:   if (AXI_bready) ws_d = W_IDLE;
    endcase
  end

  // The completing handshake's own fields are used directly so
  // the update lands on the same edge that enters W_RESP.
  assign wr_done = (ws_q != W_RESP) && (ws_d == W_RESP);
  assign wr_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign wr_oor  = aw_hs ? aw_oor : aw_oor_q;
  assign wr_data = w_hs ? AXI_wdata : wdata_q;
  assign wr_strb = w_hs ? AXI_wstrb : wstrb_q;
  assign wr_ok   = !wr_oor && !wr_idx[3];
  assign old_word = ctrl_q[{wr_idx[2:0], 5'b0} +: 32];

  axi_lite_bytewrite u_bw (
    .old_i    (old_word),
    .new_i    (wr_data),
    .strb_i   (wr_strb),
    .merged_o (new_word)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    pulse_d = '0;
    bresp_d = bresp_q;
    if (wr_done) begin
      bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        ctrl_d[{wr_idx[2:0], 5'b0} +: 32] = new_word;
        pulse_d[wr_idx[2:0]] = 1'b1;
      end
    end
  end

  // Reads sample ctrl_q, so a coinciding write returns the old value.
  always_comb begin
    rs_d        = rs_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    AXI_arready = 1'b0;
    AXI_rvalid  = 1'b0;
    unique case (rs_q)
      R_IDLE: AXI_arready = ~RESET;
      R_DATA: AXI_rvalid  = 1'b1;
    endcase
    ar_hs = AXI_arvalid & AXI_arready;
    if (ar_hs) begin
      rs_d = R_DATA;
      if (ar_oor) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (ar_idx[3]) begin
        rdata_d = status_in[{ar_idx[2:0], 5'b0} +: 32];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = ctrl_q[{ar_idx[2:0], 5'b0} +: 32];
        rresp_d = RESP_OKAY;
      end
    end else if (AXI_rvalid && AXI_rready) begin
      rs_d = R_IDLE;
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      ws_q     <= W_IDLE;
      rs_q     <= R_IDLE;
      ctrl_q   <= '0;
      pulse_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      ws_q    <= ws_d;
      rs_q    <= rs_d;
      ctrl_q  <= ctrl_d;
      pulse_q <= pulse_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_oor_q <= aw_oor;
      end
      if (w_hs) begin
        wdata_q <= AXI_wdata;
        wstrb_q <= AXI_wstrb;
      end
    end
  end

  assign ctrl_out  = ctrl_q;
  assign wr_pulse  = pulse_q;
  assign AXI_bresp = bresp_q;
  assign AXI_rresp = rresp_q;
  assign AXI_rdata = rdata_q;

endmodule

// File: tb/tb_axi_lite_responder.sv
// Self-checking bench for axi_lite_responder.
// Table vectors, directed corner sequences and a random phase vs a model.
module tb_axi_lite_responder;

  logic         AXI_CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  AXI_awaddr = '0;
  logic         AXI_awvalid = 1'b0;
  logic         AXI_awready;
  logic [31:0]  AXI_wdata = '0;
  logic [3:0]   AXI_wstrb = '0;
  logic         AXI_wvalid = 1'b0;
  logic         AXI_wready;
  logic [1:0]   AXI_bresp;
  logic         AXI_bvalid;
  logic         AXI_bready = 1'b0;
  logic [31:0]  AXI_araddr = '0;
  logic         AXI_arvalid = 1'b0;
  logic         AXI_arready;
  logic [31:0]  AXI_rdata;
  logic [1:0]   AXI_rresp;
  logic         AXI_rvalid;
  logic         AXI_rready = 1'b0;
  logic [255:0] ctrl_out;
  logic [255:0] status_in = '0;
  logic [7:0]   wr_pulse;

  axi_lite_responder #(.ADDR_WIDTH(32)) dut (
    .AXI_CLK(AXI_CLK), .RESET(RESET),
    .AXI_awaddr(AXI_awaddr), .AXI_awvalid(AXI_awvalid),
    .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
    .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
    .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid),
    .AXI_bready(AXI_bready),
    .AXI_araddr(AXI_araddr), .AXI_arvalid(AXI_arvalid),
    .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp),
    .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
    .ctrl_out(ctrl_out), .status_in(status_in),
    .wr_pulse(wr_pulse)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_reg [8];

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    int          dly;
    logic [1:0]  resp;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge AXI_CLK);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [255:0] model_ctrl();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = m_reg[k];
    return v;
  endfunction

  // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
  task automatic write_txn(input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb,
                           input int gap, input int bdly,
                           output logic [1:0] resp);
    int awst, wst, t;
    bit awd, wd, awf, wf, ok;
    logic [3:0] idx;
    logic [7:0] pexp;
    logic [1:0] rexp;
    idx = addr[5:2];
    ok = (addr[31:6] == 0) && (idx < 8);
    awst = gap < 0 ? -gap : 0;
    wst = gap > 0 ? gap : 0;
    awd = 0; wd = 0; t = 0;
    resp = 2'bxx;
    AXI_awaddr = addr;
    AXI_wdata = data;
    AXI_wstrb = strb;
    while (!(awd && wd) && t < 40) begin
      AXI_awvalid = !awd && (t >= awst);
      AXI_wvalid = !wd && (t >= wst);
      if (wd && !awd) chk("wait_have_d_wready", AXI_wready, 0);
      if (awd && !wd) chk("wait_have_a_awready", AXI_awready, 0);
      awf = AXI_awvalid && AXI_awready;
      wf = AXI_wvalid && AXI_wready;
      tick;
      if (awf) awd = 1;
      if (wf) wd = 1;
      t++;
      if (!(awd && wd)) chk("bvalid_early", AXI_bvalid, 0);
    end
    AXI_awvalid = 0;
    AXI_wvalid = 0;
    chk("wr_handshakes", {awd, wd}, 2'b11);
    if (!(awd && wd)) return;
    pexp = '0;
    if (ok) begin
      m_reg[idx[2:0]] = merge(m_reg[idx[2:0]], data, strb);
      pexp[idx[2:0]] = 1'b1;
    end
    rexp = ok ? 2'b00 : 2'b10;
    chk("bvalid_lat1", AXI_bvalid, 1);
    chk("bresp", AXI_bresp, rexp);
    chk("ctrl_out", ctrl_out, model_ctrl());
    chk("wr_pulse", wr_pulse, pexp);
    resp = AXI_bresp;
    for (int d = 0; d < bdly; d++) begin
      tick;
      chk("bvalid_hold", AXI_bvalid, 1);
      chk("bresp_hold", AXI_bresp, rexp);
      chk("no_aw_w_in_resp", {AXI_awready, AXI_wready}, 2'b00);
      chk("pulse_one_cycle", wr_pulse, 0);
    end
    AXI_bready = 1;
    tick;
    AXI_bready = 0;
    chk("bvalid_drop", AXI_bvalid, 0);
    chk("idle_awready", AXI_awready, 1);
    chk("pulse_clear", wr_pulse, 0);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int rdly,
                          output logic [31:0] rd,
                          output logic [1:0] rr);
    int t;
    logic [3:0] idx;
    logic [31:0] dexp;
    logic [1:0] rexp;
    idx = addr[5:2];
    rd = 'x;
    rr = 'x;
    AXI_araddr = addr;
    AXI_arvalid = 1;
    t = 0;
    while (!AXI_arready && t < 40) begin
      tick;
      t++;
    end
    chk("ar_accept", AXI_arready, 1);
    if (!AXI_arready) begin
      AXI_arvalid = 0;
      return;
    end
    if (addr[31:6] != 0) begin
      dexp = 0; rexp = 2'b10;
    end else if (idx >= 8) begin
      dexp = status_in[32*(idx-8) +: 32]; rexp = 2'b00;
    end else begin
      dexp = m_reg[idx[2:0]]; rexp = 2'b00;
    end
    tick;
    AXI_arvalid = 0;
    chk("rvalid", AXI_rvalid, 1);
    chk("rdata", AXI_rdata, dexp);
    chk("rresp", AXI_rresp, rexp);
    rd = AXI_rdata;
    rr = AXI_rresp;
    for (int d = 0; d < rdly; d++) begin
      tick;
      chk("rvalid_hold", AXI_rvalid, 1);
      chk("rdata_hold", AXI_rdata, dexp);
      chk("no_ar_in_rdata", AXI_arready, 0);
    end
    AXI_rready = 1;
    tick;
    AXI_rready = 0;
    chk("rvalid_drop", AXI_rvalid, 0);
    chk("arready_back", AXI_arready, 1);
  endtask

  initial begin
    logic [1:0] br, rr;
    logic [31:0] rd, a;

    for (int k = 0; k < 8; k++) begin
      m_reg[k] = '0;
      status_in[32*k +: 32] = 32'hA0A00000 | k;
    end
    status_in[63:32] = 32'h12345678;

    tbl[0]  = '{0, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[1]  = '{0, 32'h00, 32'h11223344, 4'hF, 2, 1, 2'b00, 32'h11223344};
    tbl[2]  = '{0, 32'h00, 32'h000000AA, 4'h1, -3, 0, 2'b00, 32'h112233AA};
    tbl[3]  = '{0, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 2, 2'b10, 32'h112233AA};
    tbl[4]  = '{1, 32'h40, 32'h0, 4'h0, 0, 1, 2'b10, 32'h0};
    tbl[5]  = '{1, 32'h24, 32'h0, 4'h0, 0, 4, 2'b00, 32'h12345678};
    tbl[6]  = '{0, 32'h0C, 32'h55667788, 4'h0, 0, 0, 2'b00, 32'h0};
    tbl[7]  = '{0, 32'h1C, 32'hCAFEF00D, 4'hA, -1, 0, 2'b00, 32'hCA00F000};
    tbl[8]  = '{1, 32'h1C, 32'h0, 4'h0, 0, 0, 2'b00, 32'hCA00F000};
    tbl[9]  = '{1, 32'h07, 32'h0, 4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[10] = '{0, 32'h10000004, 32'h1, 4'hF, 0, 0, 2'b10, 32'hDEADBEEF};
    tbl[11] = '{1, 32'h3C, 32'h0, 4'h0, 0, 0, 2'b00, 32'hA0A00007};

    tick;
    tick;
    chk("rst_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b000);
    chk("rst_valids", {AXI_bvalid, AXI_rvalid}, 2'b00);
    chk("rst_resp", {AXI_bresp, AXI_rresp}, 4'b0000);
    chk("rst_rdata", AXI_rdata, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_pulse", wr_pulse, 0);
    RESET = 0;
    tick;
    chk("post_rst_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b111);

    for (int i = 0; i < 12; i++) begin
      a = tbl[i].addr;
      if (tbl[i].rd) begin
        read_txn(a, tbl[i].dly, rd, rr);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].word);
        chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].resp);
      end else begin
        write_txn(a, tbl[i].data, tbl[i].strb,
                  tbl[i].gap, tbl[i].dly, br);
        chk($sformatf("tbl%0d_bresp", i), br, tbl[i].resp);
        chk($sformatf("tbl%0d_word", i),
            ctrl_out[32*a[4:2] +: 32], tbl[i].word);
      end
    end

    // Same-cycle read and write of register 2.
    write_txn(32'h08, 32'h11111111, 4'hF, 0, 0, br);
    AXI_araddr = 32'h08;
    AXI_arvalid = 1;
    AXI_awaddr = 32'h08;
    AXI_awvalid = 1;
    AXI_wdata = 32'h22222222;
    AXI_wstrb = 4'hF;
    AXI_wvalid = 1;
    chk("coin_readies", {AXI_arready, AXI_awready, AXI_wready}, 3'b111);
    tick;
    AXI_arvalid = 0;
    AXI_awvalid = 0;
    AXI_wvalid = 0;
    m_reg[2] = 32'h22222222;
    chk("coin_rvalid", AXI_rvalid, 1);
    chk("coin_rdata_old", AXI_rdata, 32'h11111111);
    chk("coin_bvalid", AXI_bvalid, 1);
    chk("coin_reg2_new", ctrl_out[95:64], 32'h22222222);
    AXI_rready = 1;
    AXI_bready = 1;
    tick;
    AXI_rready = 0;
    AXI_bready = 0;
    chk("coin_done", {AXI_rvalid, AXI_bvalid}, 2'b00);

    // Reset while holding only the write address.
    AXI_awaddr = 32'h04;
    AXI_awvalid = 1;
    tick;
    AXI_awvalid = 0;
    chk("have_a_awready", AXI_awready, 0);
    chk("have_a_wready", AXI_wready, 1);
    RESET = 1;
    tick;
    chk("mid_rst_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b000);
    chk("mid_rst_bvalid", AXI_bvalid, 0);
    chk("mid_rst_ctrl", ctrl_out, 0);
    tick;
    RESET = 0;
    for (int k = 0; k < 8; k++) m_reg[k] = '0;
    tick;
    chk("rel_readies", {AXI_awready, AXI_wready, AXI_arready}, 3'b111);
    chk("rel_bvalid", AXI_bvalid, 0);
    AXI_wdata = 32'h0BADF00D;
    AXI_wstrb = 4'hF;
    AXI_wvalid = 1;
    tick;
    AXI_wvalid = 0;
    chk("rst_discard_aw", AXI_bvalid, 0);
    chk("rst_discard_ctrl", ctrl_out, 0);
    AXI_awaddr = 32'h04;
    AXI_awvalid = 1;
    tick;
    AXI_awvalid = 0;
    m_reg[1] = 32'h0BADF00D;
    chk("post_rst_bvalid", AXI_bvalid, 1);
    chk("post_rst_ctrl", ctrl_out, model_ctrl());
    AXI_bready = 1;
    tick;
    AXI_bready = 0;

    for (int n = 0; n < 120; n++) begin
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
      if ($urandom_range(0, 5) == 0)
        status_in[32*$urandom_range(0, 7) +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1)
        write_txn(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3,
                  $urandom_range(0, 3), br);
      else
        read_txn(a, $urandom_range(0, 3), rd, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
